// File: rtl/ac_ir_pkg.sv
// Shared definitions for the AC frame builder: setting encodings, fixed
// payload fields, FSM state type and the payload encode/checksum helpers.
`timescale 1ns/1ps
package ac_ir_pkg;

   localparam logic [2:0] MODE_AUTO = 3'd0;
   localparam logic [2:0] MODE_COOL = 3'd1;
   localparam logic [2:0] MODE_DRY  = 3'd2;
   localparam logic [2:0] MODE_FAN  = 3'd3;
   localparam logic [2:0] MODE_HEAT = 3'd4;

   localparam logic [4:0] TEMP_MIN = 5'd16;
   localparam logic [4:0] TEMP_MAX = 5'd30;
   localparam logic [4:0] TEMP_RST = 5'd26;

   localparam logic [3:0] HDR_NIBBLE = 4'b0101;
   localparam logic [2:0] TOP_BITS   = 3'b010;
   localparam logic       LIGHT_BIT  = 1'b1;
   localparam logic [3:0] CSUM_BIAS  = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUILD = 2'd1,
      ST_REQ   = 2'd2,
      ST_WAIT  = 2'd3
   } fsm_state_t;

   // Packs the current settings into the 35-bit first payload word.
   function automatic logic [34:0] ac_encode(input logic       pwr,
                                             input logic [2:0] mode,
                                             input logic [4:0] temp,
                                             input logic [1:0] fan);
      logic [4:0] tdiff;
      tdiff = temp - TEMP_MIN;
      return {TOP_BITS, HDR_NIBBLE, 7'd0, LIGHT_BIT, 8'd0, tdiff[3:0],
              1'b0, 1'b0, fan, pwr, mode};
   endfunction

   // Checksum nibble of the second word: low nibble + temp nibble + 10, mod 16.
   function automatic logic [3:0] ac_checksum(input logic [34:0] d35);
      return d35[3:0] + d35[11:8] + CSUM_BIAS;
   endfunction

endpackage

// File: rtl/ac_frame_builder_if.sv
// Link between the frame builder (master) and the hongwai IR transmitter (slave).
// Handshake: the master raises key_1 with both payload words already stable and
// keeps them stable; the slave acknowledges by raising tx_busy, which ends the
// request (key_1 drops on the next edge); the payload may change again only after
// tx_busy has fallen and a new request is built.
`timescale 1ns/1ps
interface ac_frame_builder_if;
   logic        key_1;
   logic [34:0] IR_in_data35;
   logic [31:0] IR_in_data32;
   logic        tx_busy;

   modport master (output key_1, IR_in_data35, IR_in_data32, input tx_busy);
   modport slave  (input key_1, IR_in_data35, IR_in_data32, output tx_busy);
endinterface

// File: rtl/ac_frame_builder_debounce.sv
// Single-key debouncer: 2-flop synchroniser, stability counter that restarts on
// every level change, and a one-cycle event on an accepted 0->1 transition.
`timescale 1ns/1ps
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic press
);
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1, sync2, sync3;
   logic          level;
   logic [CW-1:0] cnt;
   logic          stable_done;

   assign stable_done = (sync2 == sync3) && (cnt == CNT_MAX);

   // synchroniser plus one extra flop to spot level changes
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   // count stable cycles, restarting whenever the synchronised level moves
   always_ff @(posedge clk) begin
      if (!rst)                cnt <= '0;
      else if (sync2 != sync3) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
   end

   // accept the stable level and flag a rising edge exactly once
   always_ff @(posedge clk) begin
      if (!rst) begin
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         press <= stable_done & sync3 & ~level;
         if (stable_done) level <= sync3;
      end
   end
endmodule

// File: rtl/ac_frame_builder.sv
// AC front end: debounces the panel keys, keeps the AC settings, encodes the
// two Gree-style payload words and requests a send from hongwai.
`timescale 1ns/1ps
module ac_frame_builder
   import ac_ir_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REQ_TIMEOUT     = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                key_power,
   input  logic                key_mode,
   input  logic                key_temp_up,
   input  logic                key_temp_down,
   input  logic                key_fan,
   ac_frame_builder_if.master  ir,
   output logic                tx_fault,
   output logic                power_on,
   output fsm_state_t          state_dbg
);
   localparam int RCW = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;
   localparam logic [RCW-1:0] REQ_MAX = RCW'(REQ_TIMEOUT - 1);

   logic [4:0]  raw_keys, press;
   logic        pwr, pending;
   logic [2:0]  mode;
   logic [4:0]  temp;
   logic [1:0]  fan;
   logic        ev_power, ev_mode, ev_up, ev_down, ev_fan, accept;
   fsm_state_t  state, next_state;
   logic        build_en, req_timeout, req_ack;
   logic [RCW-1:0] req_cnt;
   logic [34:0] data35_q, frame35;
   logic [31:0] data32_q;

   // bit order sets event priority: power highest, fan lowest
   assign raw_keys = {key_fan, key_temp_down, key_temp_up, key_mode, key_power};

   for (genvar k = 0; k < 5; k++) begin : g_db
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .rst   (rst),
         .raw   (raw_keys[k]),
         .press (press[k])
      );
   end

   // pick the single highest-priority event; setting keys need power on
   always_comb begin
      ev_power = press[0];
      ev_mode  = ~press[0]   & press[1] & pwr;
      ev_up    = ~|press[1:0] & press[2] & pwr;
      ev_down  = ~|press[2:0] & press[3] & pwr;
      ev_fan   = ~|press[3:0] & press[4] & pwr;
      accept   = ev_power | ev_mode | ev_up | ev_down | ev_fan;
   end

   // settings registers, updated in any FSM state
   always_ff @(posedge clk) begin
      if (!rst) begin
         pwr  <= 1'b0;
         mode <= MODE_COOL;
         temp <= TEMP_RST;
         fan  <= 2'd0;
      end else begin
         if (ev_power) pwr <= ~pwr;
         if (ev_mode)  mode <= (mode == MODE_HEAT) ? MODE_AUTO : mode + 3'd1;
         if (ev_up && temp != TEMP_MAX)   temp <= temp + 5'd1;
         if (ev_down && temp != TEMP_MIN) temp <= temp - 5'd1;
         if (ev_fan)   fan <= fan + 2'd1;
      end
   end

   // pending: a new event wins over the clear in BUILD, forcing a follow-up frame
   always_ff @(posedge clk) begin
      if (!rst)          pending <= 1'b0;
      else if (accept)   pending <= 1'b1;
      else if (build_en) pending <= 1'b0;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= next_state;
   end

   // FSM next state and control strobes
   always_comb begin
      next_state  = state;
      build_en    = 1'b0;
      req_timeout = 1'b0;
      req_ack     = 1'b0;
      case (state)
         ST_IDLE:  if (pending) next_state = ST_BUILD;
         ST_BUILD: begin
            build_en   = 1'b1;
            next_state = ST_REQ;
         end
         ST_REQ: begin
            if (ir.tx_busy) begin
               req_ack    = 1'b1;
               next_state = ST_WAIT;
            end else if (req_cnt == REQ_MAX) begin
               req_timeout = 1'b1;
               next_state  = ST_IDLE;
            end
         end
         ST_WAIT:  if (!ir.tx_busy) next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   // cycles spent in REQ without acknowledgement
   always_ff @(posedge clk) begin
      if (!rst)                req_cnt <= '0;
      else if (state == ST_REQ) req_cnt <= req_cnt + 1'b1;
      else                     req_cnt <= '0;
   end

   // sticky fault: set on timeout, cleared by the next acknowledged request
   always_ff @(posedge clk) begin
      if (!rst)             tx_fault <= 1'b0;
      else if (req_timeout) tx_fault <= 1'b1;
      else if (req_ack)     tx_fault <= 1'b0;
   end

   assign frame35 = ac_encode(pwr, mode, temp, fan);

   // payload words frozen only in BUILD so they stay stable during a send
   always_ff @(posedge clk) begin
      if (!rst) begin
         data35_q <= ac_encode(1'b0, MODE_COOL, TEMP_RST, 2'd0);
         data32_q <= {ac_checksum(ac_encode(1'b0, MODE_COOL, TEMP_RST, 2'd0)), 28'd0};
      end else if (build_en) begin
         data35_q <= frame35;
         data32_q <= {ac_checksum(frame35), 28'd0};
      end
   end

   assign ir.key_1        = (state == ST_REQ);
   assign ir.IR_in_data35 = data35_q;
   assign ir.IR_in_data32 = data32_q;
   assign power_on        = pwr;
   assign state_dbg       = state;
endmodule

// File: tb/tb_ac_frame_builder.sv
// Directed bench for ac_frame_builder with a small hongwai responder model.
`timescale 1ns/1ps
module tb_ac_frame_builder;
   import ac_ir_pkg::*;

   localparam int DEB = 4;
   localparam int TO  = 16;
   localparam logic [34:0] RST35 = 35'h2_5010_0A01;
   localparam logic [31:0] RST32 = 32'h5000_0000;

   typedef struct {
      int          key;
      int          frames;
      logic [34:0] d35;
      logic [31:0] d32;
      logic        pwr;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #10 clk = ~clk;

   logic [4:0] keys = '0;
   logic       tx_fault, power_on;
   fsm_state_t state_dbg;
   ac_frame_builder_if ifc();

   ac_frame_builder #(.DEBOUNCE_CYCLES(DEB), .REQ_TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst           (rst),
      .key_power     (keys[0]),
      .key_mode      (keys[1]),
      .key_temp_up   (keys[2]),
      .key_temp_down (keys[3]),
      .key_fan       (keys[4]),
      .ir            (ifc),
      .tx_fault      (tx_fault),
      .power_on      (power_on),
      .state_dbg     (state_dbg)
   );

   int checks = 0;
   int failures = 0;

   // ---------------- hongwai model: busy 2 cycles after key_1, for 10 cycles
   logic hw_en = 1'b1;
   logic hw_k1_prev = 1'b0;
   int   hw_delay = 0;
   int   hw_left = 0;
   always @(negedge clk) begin
      if (!rst || !hw_en) begin
         ifc.tx_busy = 1'b0;
         hw_delay = 0;
         hw_left = 0;
      end else if (hw_left > 0) begin
         hw_left--;
         if (hw_left == 0) ifc.tx_busy = 1'b0;
      end else if (hw_delay > 0) begin
         hw_delay--;
         if (hw_delay == 0) begin
            ifc.tx_busy = 1'b1;
            hw_left = 10;
         end
      end else if (ifc.key_1 && !hw_k1_prev) begin
         hw_delay = 2;
      end
      hw_k1_prev = ifc.key_1;
   end

   // ---------------- request monitor: frame count and key_1 pulse length
   int   frames = 0;
   int   hi_len = 0;
   int   last_hi_len = 0;
   logic k1_prev = 1'b0;
   always @(posedge clk) begin
      #1;
      if (ifc.key_1 && !k1_prev) begin
         frames++;
         hi_len = 0;
      end
      if (ifc.key_1) hi_len++;
      else if (k1_prev) last_hi_len = hi_len;
      k1_prev = ifc.key_1;
   end

   // ---------------- driver / checker tasks ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic press(input int k);
      keys[k] = 1'b1;
      tick(8);
      keys[k] = 1'b0;
      tick(8);
   endtask

   task automatic settle();
      int idle = 0;
      int n = 0;
      while (idle < 4 && n < 400) begin
         tick();
         n++;
         if (state_dbg == ST_IDLE) idle++;
         else idle = 0;
      end
      checks++;
      if (idle < 4) begin
         failures++;
         $display("FAIL settle: FSM not idle after %0d cycles", n);
      end
   endtask

   task automatic wait_key1(input int budget);
      int n = 0;
      while (!ifc.key_1 && n < budget) begin
         tick();
         n++;
      end
      check("wait_key_1", 64'(ifc.key_1), 64'(1'b1));
   endtask

   task automatic wait_state(input fsm_state_t st, input int budget);
      int n = 0;
      while (state_dbg != st && n < budget) begin
         tick();
         n++;
      end
      check("wait_state", 64'(state_dbg), 64'(st));
   endtask

   task automatic check_frame(input string name, input logic [34:0] e35, input logic [31:0] e32);
      check({name, "_d35"}, 64'(ifc.IR_in_data35), 64'(e35));
      check({name, "_d32"}, 64'(ifc.IR_in_data32), 64'(e32));
   endtask

   // ---------------- stimulus ----------------
   vec_t vt[15];

   initial begin
      int f0;
      int d;
      logic saw_k1;

      vt[0]  = '{1, 1, 35'h2_5010_0A0A, 32'hE000_0000, 1'b1};
      vt[1]  = '{1, 1, 35'h2_5010_0A0B, 32'hF000_0000, 1'b1};
      vt[2]  = '{1, 1, 35'h2_5010_0A0C, 32'h0000_0000, 1'b1};
      vt[3]  = '{1, 1, 35'h2_5010_0A08, 32'hC000_0000, 1'b1};
      vt[4]  = '{4, 1, 35'h2_5010_0A18, 32'hC000_0000, 1'b1};
      vt[5]  = '{4, 1, 35'h2_5010_0A28, 32'hC000_0000, 1'b1};
      vt[6]  = '{4, 1, 35'h2_5010_0A38, 32'hC000_0000, 1'b1};
      vt[7]  = '{4, 1, 35'h2_5010_0A08, 32'hC000_0000, 1'b1};
      vt[8]  = '{3, 1, 35'h2_5010_0908, 32'hB000_0000, 1'b1};
      vt[9]  = '{2, 1, 35'h2_5010_0A08, 32'hC000_0000, 1'b1};
      vt[10] = '{0, 1, 35'h2_5010_0A00, 32'h4000_0000, 1'b0};
      vt[11] = '{1, 0, 35'h2_5010_0A00, 32'h4000_0000, 1'b0};
      vt[12] = '{2, 0, 35'h2_5010_0A00, 32'h4000_0000, 1'b0};
      vt[13] = '{4, 0, 35'h2_5010_0A00, 32'h4000_0000, 1'b0};
      vt[14] = '{0, 1, 35'h2_5010_0A08, 32'hC000_0000, 1'b1};

      // 1. reset values, then idle with no keys
      rst = 1'b0;
      tick(5);
      check("rst_key_1", 64'(ifc.key_1), 64'(1'b0));
      check_frame("rst", RST35, RST32);
      rst = 1'b1;
      saw_k1 = 1'b0;
      repeat (20) begin
         tick();
         if (ifc.key_1) saw_k1 = 1'b1;
      end
      check("idle_key_1", 64'(saw_k1), 64'(1'b0));
      check("idle_frames", 64'(frames), 64'(0));
      check_frame("idle", RST35, RST32);
      check("idle_fault", 64'(tx_fault), 64'(1'b0));
      check("idle_power", 64'(power_on), 64'(1'b0));
      check("idle_state", 64'(state_dbg), 64'(ST_IDLE));

      // 2. clean power press
      f0 = frames;
      keys[0] = 1'b1;
      wait_key1(40);
      check_frame("pwr_on", 35'h2_5010_0A09, 32'hD000_0000);
      d = 0;
      while (!ifc.tx_busy && d < 20) begin
         tick();
         d++;
      end
      check("busy_seen", 64'(ifc.tx_busy), 64'(1'b1));
      check("key_1_drop", 64'(ifc.key_1), 64'(1'b0));
      keys[0] = 1'b0;
      tick(8);
      settle();
      check("pwr_on_frames", 64'(frames - f0), 64'(1));
      check("pwr_on_power", 64'(power_on), 64'(1'b1));

      // table of single presses
      for (int i = 0; i < 15; i++) begin
         f0 = frames;
         press(vt[i].key);
         settle();
         check($sformatf("vec%0d_frames", i), 64'(frames - f0), 64'(vt[i].frames));
         check_frame($sformatf("vec%0d", i), vt[i].d35, vt[i].d32);
         check($sformatf("vec%0d_power", i), 64'(power_on), 64'(vt[i].pwr));
      end

      // 3. bouncing power key: one accepted press, one frame
      f0 = frames;
      for (int i = 0; i < 10; i++) begin
         keys[0] = ~keys[0];
         tick(2);
      end
      keys[0] = 1'b1;
      tick(12);
      keys[0] = 1'b0;
      tick(8);
      settle();
      check("bounce_frames", 64'(frames - f0), 64'(1));
      check("bounce_power", 64'(power_on), 64'(1'b0));
      check_frame("bounce", 35'h2_5010_0A00, 32'h4000_0000);
      f0 = frames;
      press(0);
      settle();
      check("repower_frames", 64'(frames - f0), 64'(1));
      check_frame("repower", 35'h2_5010_0A08, 32'hC000_0000);

      // 4. temp saturation at 30
      f0 = frames;
      repeat (4) press(2);
      settle();
      d = frames - f0;
      check("sat_frames_range", 64'(d >= 1 && d <= 4), 64'(1));
      check_frame("sat4", 35'h2_5010_0E08, 32'h0000_0000);
      f0 = frames;
      press(2);
      settle();
      check("sat5_frames", 64'(frames - f0), 64'(1));
      check_frame("sat5", 35'h2_5010_0E08, 32'h0000_0000);

      // 5. mode press during WAIT gives exactly one follow-up frame
      press(1);
      settle();
      check_frame("mode1", 35'h2_5010_0E09, 32'h1000_0000);
      f0 = frames;
      keys[2] = 1'b1;
      wait_key1(40);
      wait_state(ST_WAIT, 20);
      keys[1] = 1'b1;
      tick(8);
      keys[1] = 1'b0;
      keys[2] = 1'b0;
      tick(8);
      settle();
      check("wait_follow_frames", 64'(frames - f0), 64'(2));
      check_frame("wait_follow", 35'h2_5010_0E0A, 32'h2000_0000);

      // 6a. no acknowledgement: timeout and sticky fault
      hw_en = 1'b0;
      f0 = frames;
      press(4);
      settle();
      check("to_frames", 64'(frames - f0), 64'(1));
      check("to_len", 64'(last_hi_len), 64'(TO));
      check("to_fault", 64'(tx_fault), 64'(1'b1));
      check_frame("to", 35'h2_5010_0E1A, 32'h2000_0000);

      // 6b. next good send clears the fault
      hw_en = 1'b1;
      f0 = frames;
      press(4);
      settle();
      check("clr_frames", 64'(frames - f0), 64'(1));
      check("clr_fault", 64'(tx_fault), 64'(1'b0));
      check_frame("clr", 35'h2_5010_0E2A, 32'h2000_0000);

      // 6c. reset during REQ drops key_1 on the next edge
      keys[4] = 1'b1;
      wait_key1(40);
      rst = 1'b0;
      keys[4] = 1'b0;
      tick(1);
      check("rreq_key_1", 64'(ifc.key_1), 64'(1'b0));
      check("rreq_state", 64'(state_dbg), 64'(ST_IDLE));
      check("rreq_power", 64'(power_on), 64'(1'b0));
      check_frame("rreq", RST35, RST32);
      tick(3);
      rst = 1'b1;
      f0 = frames;
      tick(20);
      check("rreq_quiet", 64'(frames - f0), 64'(0));
      check("rreq_fault", 64'(tx_fault), 64'(1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // hard stop so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule
